// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host-side transmitter and its companions:
// FSM state encoding, error codes reported on completion, and the common
// keyboard command bytes.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    HOLD,
    SEND,
    ACK,
    RELEASE
  } ps2_state_t;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_NOACK   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  localparam logic [7:0] CMD_LEDS  = 8'hED;
  localparam logic [7:0] CMD_RESET = 8'hFF;
  localparam logic [7:0] CMD_RATE  = 8'hF3;

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchroniser for the raw PS/2 clock and data pads, plus a
// registered falling-edge detector on the synchronised clock. Lines idle
// high, so the flops come out of reset at 1 to avoid a false edge.
module ps2_sync (
  input  logic clock,
  input  logic reset_n,
  input  logic ps_clk,
  input  logic ps_dat,
  output logic clk_s,
  output logic dat_s,
  output logic fall
);

  logic [1:0] clk_ff;
  logic [1:0] dat_ff;
  logic       clk_prev;
  logic       fall_q;

  // Metastability flops and one-cycle-late falling-edge strobe.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      clk_ff   <= 2'b11;
      dat_ff   <= 2'b11;
      clk_prev <= 1'b1;
      fall_q   <= 1'b0;
    end else begin
      clk_ff   <= {clk_ff[0], ps_clk};
      dat_ff   <= {dat_ff[0], ps_dat};
      clk_prev <= clk_ff[1];
      fall_q   <= clk_prev & ~clk_ff[1];
    end
  end

  assign clk_s = clk_ff[1];
  assign dat_s = dat_ff[1];
  assign fall  = fall_q;

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter. Pulls the clock low to inhibit the
// device, requests to send by pulling data low, then shifts start/data/
// parity/stop on device-generated clock falls and checks the ack bit.
// Optional build macro PS2TX_RETRY_EN: a failed attempt (no ack or
// timeout) is retried from INHIBIT up to RETRIES extra times, reporting
// done/error only for the final attempt.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int HOLD_CYCLES    = 25,
  parameter int TIMEOUT_CYCLES = 375000,
  parameter int RETRIES        = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps_clk,
  input  logic       ps_dat,
  output logic       clk_oe,
  output logic       dat_oe,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic [1:0] error,
  output logic       rx_inhibit
);

  localparam int TMR_MAX = (INHIBIT_CYCLES > HOLD_CYCLES) ? INHIBIT_CYCLES : HOLD_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AT_W    = $clog2(RETRIES + 2);

  localparam logic [TMR_W-1:0] INH_LOAD  = TMR_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_MAX    = WD_W'(TIMEOUT_CYCLES);
  localparam logic [AT_W-1:0]  RETRY_MAX = AT_W'(RETRIES);

`ifdef PS2TX_RETRY_EN
  localparam bit RETRY_ON = 1'b1;
`else
  localparam bit RETRY_ON = 1'b0;
`endif

  logic clk_s;
  logic dat_s;
  logic fall;

  ps2_sync u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .ps_clk  (ps_clk),
    .ps_dat  (ps_dat),
    .clk_s   (clk_s),
    .dat_s   (dat_s),
    .fall    (fall)
  );

  ps2_state_t       state_q,  state_d;
  logic [TMR_W-1:0] tmr_q,    tmr_d;
  logic [WD_W-1:0]  wd_q,     wd_d;
  logic [3:0]       bit_q,    bit_d;
  logic [7:0]       data_q,   data_d;
  logic             par_q,    par_d;
  logic             clk_oe_q, clk_oe_d;
  logic             dat_oe_q, dat_oe_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [1:0]       err_q,    err_d;
  logic [1:0]       pend_q,   pend_d;
  logic [AT_W-1:0]  att_q,    att_d;

  logic             fin_req;
  logic [1:0]       fin_code;
  logic             can_retry;
  logic             wd_live;

  assign can_retry = RETRY_ON && (att_q < RETRY_MAX);
  assign wd_live   = (state_q == SEND) || (state_q == ACK) || (state_q == RELEASE);

  // Next-state and output decode; a finishing attempt either retries or
  // reports, and the watchdog expiry overrides whatever the state wanted.
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    bit_d    = bit_q;
    data_d   = data_q;
    par_d    = par_q;
    clk_oe_d = clk_oe_q;
    dat_oe_d = dat_oe_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    pend_d   = pend_q;
    att_d    = att_q;
    fin_req  = 1'b0;
    fin_code = ERR_OK;

    if (!wd_live || fall) begin
      wd_d = '0;
    end else if (wd_q != WD_MAX) begin
      wd_d = wd_q + 1'b1;
    end else begin
      wd_d = wd_q;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          data_d   = data;
          par_d    = odd_parity(data);
          busy_d   = 1'b1;
          err_d    = ERR_OK;
          pend_d   = ERR_OK;
          att_d    = '0;
          clk_oe_d = 1'b1;
          dat_oe_d = 1'b0;
          tmr_d    = INH_LOAD;
          state_d  = INHIBIT;
        end
      end
      INHIBIT: begin
        if (tmr_q == '0) begin
          dat_oe_d = 1'b1;
          tmr_d    = HOLD_LOAD;
          state_d  = HOLD;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      HOLD: begin
        if (tmr_q == '0) begin
          clk_oe_d = 1'b0;
          bit_d    = 4'd0;
          state_d  = SEND;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      SEND: begin
        if (fall) begin
          bit_d = bit_q + 4'd1;
          if (bit_q < 4'd8) begin
            dat_oe_d = ~data_q[bit_q[2:0]];
          end else if (bit_q == 4'd8) begin
            dat_oe_d = ~par_q;
          end else begin
            dat_oe_d = 1'b0;
            state_d  = ACK;
          end
        end
      end
      ACK: begin
        if (fall) begin
          pend_d  = dat_s ? ERR_NOACK : ERR_OK;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (clk_s && dat_s) begin
          fin_req  = 1'b1;
          fin_code = pend_q;
        end
      end
      default: begin
        state_d  = IDLE;
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase

    if (wd_live && (wd_q == WD_MAX)) begin
      fin_req  = 1'b1;
      fin_code = ERR_TIMEOUT;
    end

    if (fin_req) begin
      if ((fin_code != ERR_OK) && can_retry) begin
        att_d    = att_q + 1'b1;
        clk_oe_d = 1'b1;
        dat_oe_d = 1'b0;
        tmr_d    = INH_LOAD;
        bit_d    = 4'd0;
        state_d  = INHIBIT;
      end else begin
        done_d   = 1'b1;
        busy_d   = 1'b0;
        err_d    = fin_code;
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        state_d  = IDLE;
      end
    end
  end

  // State register; reset releases both lines on the same edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      tmr_q    <= '0;
      wd_q     <= '0;
      bit_q    <= 4'd0;
      data_q   <= 8'd0;
      par_q    <= 1'b0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= ERR_OK;
      pend_q   <= ERR_OK;
      att_q    <= '0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      wd_q     <= wd_d;
      bit_q    <= bit_d;
      data_q   <= data_d;
      par_q    <= par_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      pend_q   <= pend_d;
      att_q    <= att_d;
    end
  end

  assign clk_oe     = clk_oe_q;
  assign dat_oe     = dat_oe_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = err_q;
  assign rx_inhibit = busy_q;

endmodule
